// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 1-deep in-flight tracker and a
// 2-entry {pc, instr} output FIFO. Fetches are credit-limited so the FIFO can
// never overflow; a taken branch flushes everything and redirects fetch_pc.
//
// Optional feature: define FETCH_HALT_EN to enable the halt opcode (bits
// [15:12] == 4'hF). The halting word is delivered, then fetch stops until a
// branch redirect or reset. Without the macro, opcode 4'hF is ordinary.
//
// Ports:
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous active-high reset
//   stall           in   1   downstream cannot accept this cycle
//   branch_taken    in   1   redirect request from a later stage
//   branch_target   in   8   redirect PC
//   imem_addr       out  8   instruction memory address (fetch_pc register)
//   imem_rdata      in   16  synchronous memory data, one cycle after address
//   pc_out          out  8   PC of delivered instruction (FIFO head)
//   instruction_out out  16  delivered instruction (FIFO head)
//   valid_out       out  1   head holds a real instruction, 0 = bubble
//
// state  | meaning
// RUN    | fetching normally
// HALTED | halt word pushed; no issues until branch_taken or reset

module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [7:0]  pc_out,
    output logic [15:0] instruction_out,
    output logic        valid_out
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [7:0]  inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  fifo_pc_q [2];
    logic [7:0]  fifo_pc_d [2];
    logic [15:0] fifo_instr_q [2];
    logic [15:0] fifo_instr_d [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic        halt_hit;
    logic [2:0]  credit;
    logic [1:0]  count_after_pop;

    always_comb begin
        pop  = (count_q != 2'd0) && !stall;
        push = inflight_q;
        // Slots already claimed after this edge; pop implies count_q >= 1,
        // so the subtraction never wraps.
        credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
`ifdef FETCH_HALT_EN
        halt_hit = push && (imem_rdata[15:12] == 4'hF);
`else
        halt_hit = 1'b0;
`endif
        // The halt word's own edge must not launch the fetch behind it.
        issue = (state_q == RUN) && !halt_hit && (credit < 3'd2);

        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        inflight_d      = inflight_q;
        inflight_pc_d   = inflight_pc_q;
        count_d         = count_q;
        fifo_pc_d       = fifo_pc_q;
        fifo_instr_d    = fifo_instr_q;
        count_after_pop = count_q;

        if (branch_taken) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            fetch_pc_d = branch_target;
            state_d    = RUN;
        end else begin
            if (pop) begin
                fifo_pc_d[0]    = fifo_pc_q[1];
                fifo_instr_d[0] = fifo_instr_q[1];
                count_after_pop = count_q - 2'd1;
            end
            count_d = count_after_pop;
            if (push) begin
                fifo_pc_d[count_after_pop[0]]    = inflight_pc_q;
                fifo_instr_d[count_after_pop[0]] = imem_rdata;
                count_d = count_after_pop + 2'd1;
            end
            if (halt_hit) begin
                state_d = HALTED;
            end
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            fetch_pc_q      <= 8'h00;
            inflight_q      <= 1'b0;
            inflight_pc_q   <= 8'h00;
            count_q         <= 2'd0;
            fifo_pc_q[0]    <= 8'h00;
            fifo_pc_q[1]    <= 8'h00;
            fifo_instr_q[0] <= 16'h0000;
            fifo_instr_q[1] <= 16'h0000;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            inflight_pc_q   <= inflight_pc_d;
            count_q         <= count_d;
            fifo_pc_q[0]    <= fifo_pc_d[0];
            fifo_pc_q[1]    <= fifo_pc_d[1];
            fifo_instr_q[0] <= fifo_instr_d[0];
            fifo_instr_q[1] <= fifo_instr_d[1];
        end
    end

    assign imem_addr       = fetch_pc_q;
    assign pc_out          = fifo_pc_q[0];
    assign instruction_out = fifo_instr_q[0];
    assign valid_out       = (count_q != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Memory model returns
// 16'h1000 + addr one cycle after the address edge; word 3 is patched to
// 16'hF000 for the halt-opcode section. Inputs are driven and outputs are
// sampled on the falling edge.

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  pc_out;
    logic [15:0] instruction_out;
    logic        valid_out;

    logic [15:0] mem [256];
    int          vectors;
    int          miscompares;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_insn(input string tag, input logic [7:0] pc, input logic [15:0] ins);
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
        chk({tag, ".instr"}, 32'(instruction_out), 32'(ins));
    endtask

    task automatic expect_bubble(input string tag);
        chk({tag, ".valid"}, 32'(valid_out), 32'd0);
    endtask

    task automatic redirect(input logic [7:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        @(negedge clk);
        expect_bubble("redir_edge");
        branch_taken = 1'b0;
        stall        = 1'b0;
        @(negedge clk);
        expect_bubble("redir_issue");
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        imem_rdata    = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

        // Reset state; stall and branch are ignored while rst is high.
        @(negedge clk);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h77;
        @(negedge clk);
        chk("rst.valid", 32'(valid_out), 32'd0);
        chk("rst.pc", 32'(pc_out), 32'h00);
        chk("rst.instr", 32'(instruction_out), 32'h0000);
        chk("rst.addr", 32'(imem_addr), 32'h00);
        stall        = 1'b0;
        branch_taken = 1'b0;
        rst          = 1'b0;

        // Streaming from reset: first valid after the second edge.
        @(negedge clk);
        expect_bubble("rel_c1");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expect_insn("stream", 8'(i), 16'h1000 + 16'(i));
        end

        // Stall 3 cycles holding pc 05.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_insn("stall_hold", 8'h05, 16'h1005);
        end
        stall = 1'b0;
        for (int i = 6; i < 9; i++) begin
            @(negedge clk);
            expect_insn("post_stall", 8'(i), 16'h1000 + 16'(i));
        end

        // Fill FIFO under stall, then branch to 40 with stall still high.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_insn("fill_hold", 8'h08, 16'h1008);
        end
        redirect(8'h40);
        @(negedge clk);
        expect_insn("br40_a", 8'h40, 16'h1040);
        @(negedge clk);
        expect_insn("br40_b", 8'h41, 16'h1041);

        // PC wrap FE -> FF -> 00 -> 01.
        redirect(8'hFE);
        @(negedge clk);
        expect_insn("wrap_fe", 8'hFE, 16'h10FE);
        @(negedge clk);
        expect_insn("wrap_ff", 8'hFF, 16'h10FF);
        @(negedge clk);
        expect_insn("wrap_00", 8'h00, 16'h1000);
        @(negedge clk);
        expect_insn("wrap_01", 8'h01, 16'h1001);

        // Mid-stream reset pulse with a fetch in flight.
        rst = 1'b1;
        #1;
        chk("mrst.valid", 32'(valid_out), 32'd0);
        chk("mrst.pc", 32'(pc_out), 32'h00);
        chk("mrst.instr", 32'(instruction_out), 32'h0000);
        chk("mrst.addr", 32'(imem_addr), 32'h00);
        #1;
        rst = 1'b0;
        @(negedge clk);
        expect_bubble("mrst_c1");
        @(negedge clk);
        expect_insn("mrst_c2", 8'h00, 16'h1000);
        @(negedge clk);
        expect_insn("mrst_c3", 8'h01, 16'h1001);

        // Opcode 4'hF at address 03.
        mem[3] = 16'hF000;
        redirect(8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_insn("op_pre", 8'(i), 16'h1000 + 16'(i));
        end
        @(negedge clk);
        expect_insn("op_f", 8'h03, 16'hF000);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_bubble("halted");
            chk("halted.addr", 32'(imem_addr), 32'h04);
        end
        redirect(8'h10);
        @(negedge clk);
        expect_insn("resume_a", 8'h10, 16'h1010);
        @(negedge clk);
        expect_insn("resume_b", 8'h11, 16'h1011);
`else
        @(negedge clk);
        expect_insn("no_halt_a", 8'h04, 16'h1004);
        @(negedge clk);
        expect_insn("no_halt_b", 8'h05, 16'h1005);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
